// File: rtl/if_id_skid_pkg.sv
// -----------------------------------------------------------------------------
// if_id_skid_pkg
// Shared types for the fetch-to-decode boundary of the pipelined MIPS core.
//   beat_t          : one fetch beat {instruction, PC_plus_4}
//   NOP_INSTR       : encoding presented to decode when no instruction is valid
//   skid_state_t    : occupancy of the 2-entry skid buffer (EMPTY/ONE/TWO)
// -----------------------------------------------------------------------------
package if_id_skid_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [PC_W-1:0]    PC_plus_4;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/if_id_sat_counter.sv
// -----------------------------------------------------------------------------
// if_id_sat_counter
// 32-bit event counter that increments while en is high and sticks at
// 32'hFFFF_FFFF instead of wrapping.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset, clears count
//   en     in  count this cycle
//   count  out current count
// -----------------------------------------------------------------------------
module if_id_sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// -----------------------------------------------------------------------------
// if_id_skid
// Fetch-to-decode boundary. A 2-entry skid buffer (main + skid) accepts fetch
// beats on a valid/ready handshake and presents one instruction per cycle to
// decode. if_ready is a flop so fetch never sees a combinational path from
// decode's stall. Supports hazard stalls, branch flushes and a sticky halt.
// When nothing is valid the outputs are forced to a NOP bubble.
//
// Optional build macro: IF_ID_PERF_CNT_EN
//   defined   -> stall_count / bubble_count are live saturating counters
//   undefined -> counter logic absent, both ports tied to 0
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_valid, if_ready         fetch handshake (if_ready registered)
//   if_instruction, if_PC_plus_4  fetch beat payload
//   id_stall                   decode holds current output
//   flush                      discard everything buffered and in flight
//   halt                       stop accepting beats (sticky until reset)
//   id_valid                   outputs hold a real instruction
//   instruction_copy, PC_plus_4_copy  beat to decode (0 when !id_valid)
//   halted_copy                sticky halt flag
//   stall_count, bubble_count  performance counters
// -----------------------------------------------------------------------------
module if_id_skid
    import if_id_skid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_PC_plus_4,
    input  logic        id_stall,
    input  logic        flush,
    input  logic        halt,
    output logic        id_valid,
    output logic [31:0] instruction_copy,
    output logic [31:0] PC_plus_4_copy,
    output logic        halted_copy,
    output logic [31:0] stall_count,
    output logic [31:0] bubble_count
);

    skid_state_t state_reg;
    skid_state_t state_next;
    beat_t       main_reg;
    beat_t       skid_reg;
    beat_t       in_beat;
    logic        accept;
    logic        consume;
    logic        halted_next;

    assign in_beat  = '{instruction: if_instruction, PC_plus_4: if_PC_plus_4};
    assign id_valid = (state_reg != EMPTY);
    assign accept   = if_valid && if_ready;
    assign consume  = id_valid && !id_stall;
    assign halted_next = halted_copy || halt;

    // Occupancy transitions; flush overrides stall and any same-cycle accept.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY:   if (accept) state_next = ONE;
                ONE: begin
                    if (consume && !accept)      state_next = EMPTY;
                    else if (!consume && accept) state_next = TWO;
                end
                TWO:     if (consume) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= EMPTY;
            main_reg    <= '0;
            skid_reg    <= '0;
            if_ready    <= 1'b1;
            halted_copy <= 1'b0;
        end else begin
            state_reg   <= state_next;
            halted_copy <= halted_next;
            // Ready is derived from next state so it is accurate the cycle
            // the skid fills or drains, without a combinational path.
            if_ready    <= (state_next != TWO) && !halted_next;
            if (!flush) begin
                case (state_reg)
                    EMPTY: if (accept) main_reg <= in_beat;
                    ONE: begin
                        if (consume && accept) main_reg <= in_beat;
                        else if (accept)       skid_reg <= in_beat;
                    end
                    TWO:   if (consume) main_reg <= skid_reg;
                    default: ;
                endcase
            end
        end
    end

    // Bubble: decode sees a NOP with zero PC whenever main is empty.
    assign instruction_copy = id_valid ? main_reg.instruction : NOP_INSTR;
    assign PC_plus_4_copy   = id_valid ? main_reg.PC_plus_4   : 32'd0;

`ifdef IF_ID_PERF_CNT_EN
    if_id_sat_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (id_valid && id_stall),
        .count (stall_count)
    );

    if_id_sat_counter u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!id_valid),
        .count (bubble_count)
    );
`else
    assign stall_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

endmodule
